// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and types for the fetch PC generator and its predictor.
package fetch_pc_gen_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  // Killed responses that may still be in flight: one from the request the
  // redirect abandoned, plus one from a request issued while already killing.
  localparam logic [1:0]  KILL_MAX   = 2'd2;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PRED_SEQ = 2'd0,
    PRED_JAL = 2'd1,
    PRED_BR  = 2'd2
  } pred_kind_e;

  // Static prediction class: JAL always taken, branches taken only when the
  // offset is negative (sign bit is instr[31] for the B-format immediate).
  function automatic pred_kind_e pred_kind(input logic [31:0] instr);
    pred_kind_e kind;
    kind = PRED_SEQ;
    if (instr[6:0] == OPC_JAL) begin
      kind = PRED_JAL;
    end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
      kind = PRED_BR;
    end
    return kind;
  endfunction

endpackage

// File: rtl/fetch_pred.sv
// Combinational static next-PC predictor: immediate decode plus one adder.
module fetch_pred
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic [31:0]         instr,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pred_pc
);

  logic [20:0]         j_imm;
  logic [12:0]         b_imm;
  logic [PC_WIDTH-1:0] offset;

  // Decode both immediate formats and select the offset by prediction class.
  always_comb begin
    j_imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    offset = PC_WIDTH'(32'd4);
    unique case (pred_kind(instr))
      PRED_JAL: offset = {{(PC_WIDTH-21){j_imm[20]}}, j_imm};
      PRED_BR:  offset = {{(PC_WIDTH-13){b_imm[12]}}, b_imm};
      default:  offset = PC_WIDTH'(32'd4);
    endcase
    // Wraps modulo 2^PC_WIDTH by construction.
    pred_pc = pc + offset;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-side producer for the F register: issues imem requests for the
// current F PC, hands the fetched word to decode and supplies the next PC.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PC_WIDTH-1:0] F_predPC_i,
  output logic [PC_WIDTH-1:0] f_predPC_o,
  output logic                f_stall_o,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  output logic                f_valid_o,
  output logic [31:0]         f_instr_o,
  output logic [PC_WIDTH-1:0] f_pc_o,
  input  logic                D_ready_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i
);

  fetch_state_e        state_q, state_d;
  logic [1:0]          kill_q, kill_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pred_pc;

  logic req;
  logic granted;
  logic rsp_live;
  logic rsp_killed;
  logic handoff;
  logic kill_add;
  logic in_idle;

  fetch_pred #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pred (
    .instr   (instr_q),
    .pc      (pc_q),
    .pred_pc (pred_pc)
  );

  // Handshake decode shared by outputs and next-state logic.
  always_comb begin
    in_idle    = (state_q == FS_IDLE);
    // Stop issuing while the kill budget is exhausted so in-flight data stays bounded.
    req        = (state_q == FS_REQ) && (kill_q < KILL_MAX);
    granted    = req && imem_gnt_i;
    rsp_killed = imem_rvalid_i && (kill_q != 2'd0);
    rsp_live   = imem_rvalid_i && (kill_q == 2'd0) && (state_q == FS_WAIT);
    handoff    = (state_q == FS_HOLD) && D_ready_i && !redirect_i;
    // A redirect orphans the live request if it was granted but not yet answered.
    kill_add   = redirect_i && (((state_q == FS_WAIT) && !rsp_live) || granted);
  end

  // Output drive: F-register control is combinational, decode data is registered.
  always_comb begin
    imem_req_o  = req;
    imem_addr_o = in_idle ? RESET_PC : F_predPC_i;
    f_stall_o   = !(handoff || redirect_i);
    if (redirect_i) begin
      f_predPC_o = redirect_pc_i;
    end else if (handoff) begin
      f_predPC_o = pred_pc;
    end else begin
      f_predPC_o = in_idle ? RESET_PC : F_predPC_i;
    end
    // Suppress the offer in the redirect cycle so decode cannot take a flushed word.
    f_valid_o = valid_q && !redirect_i;
    f_instr_o = instr_q;
    f_pc_o    = pc_q;
  end

  // Next-state, capture and kill bookkeeping.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    kill_d  = kill_q - {1'b0, rsp_killed} + {1'b0, kill_add};

    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ:  if (granted) state_d = FS_WAIT;
      FS_WAIT: begin
        if (rsp_live) begin
          state_d = FS_HOLD;
          valid_d = 1'b1;
          instr_d = imem_rdata_i;
          // F is stalled across the request, so it still holds the fetched PC.
          pc_d    = F_predPC_i;
        end
      end
      FS_HOLD: begin
        if (handoff) begin
          state_d = FS_REQ;
          valid_d = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (redirect_i) begin
      state_d = FS_REQ;
      valid_d = 1'b0;
      instr_d = instr_q;
      pc_d    = pc_q;
    end
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FS_IDLE;
      kill_q  <= 2'd0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: in-order memory model, F register
// model and a transaction-level PC/prediction reference.
module tb_fetch_pc_gen;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        rst_n;
  logic [63:0] f_reg;
  logic [63:0] f_predPC;
  logic        f_stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [63:0] f_pc;
  logic        d_ready;
  logic        redirect;
  logic [63:0] redirect_pc;

  fetch_pc_gen #(
    .PC_WIDTH (64),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .F_predPC_i    (f_reg),
    .f_predPC_o    (f_predPC),
    .f_stall_o     (f_stall),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .f_valid_o     (f_valid),
    .f_instr_o     (f_instr),
    .f_pc_o        (f_pc),
    .D_ready_i     (d_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // F pipeline register model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_reg <= RESET_PC;
    else if (!f_stall) f_reg <= f_predPC;
  end

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic [31:0] imem [logic [63:0]];
  pend_t       pend_q [$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;
  int          handoffs = 0;
  int          last_gnt_cyc = 0;
  int          last_handoff_cyc = 0;
  bit          granted_now;
  bit          handoff_now;
  logic [63:0] model_pc = RESET_PC;
  logic [63:0] last_pred;

  int          gnt_pct = 100;
  int          ready_pct = 100;
  int          redir_pml = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          redir_once = 1'b0;
  logic [63:0] redir_target = 64'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(3);
    if (k == 0) return {r[31:7], 7'b1101111};
    if (k == 1) return {r[31:7], 7'b1100011};
    return {r[31:7], 7'b0010011};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [63:0] addr);
    if (!imem.exists(addr)) imem[addr] = gen_word();
    return imem[addr];
  endfunction

  // Reference next PC from the instruction-set rules, using plain arithmetic.
  function automatic logic [63:0] ref_pred(input logic [31:0] w, input logic [63:0] pc);
    logic [63:0] off;
    off = 64'd4;
    if (w[6:0] == 7'b1101111) begin
      off = 64'(w[30:21]) * 64'd2 + 64'(w[20]) * 64'd2048 + 64'(w[19:12]) * 64'd4096
            - (w[31] ? 64'h100000 : 64'h0);
    end else if (w[6:0] == 7'b1100011 && w[31]) begin
      off = 64'(w[11:8]) * 64'd2 + 64'(w[30:25]) * 64'd32 + 64'(w[7]) * 64'd2048
            - 64'd4096;
    end
    return pc + off;
  endfunction

  // One clock cycle: drive inputs just after the edge, check, advance.
  task automatic step();
    pend_t       p;
    logic [63:0] tgt;
    logic [63:0] exp_pred;
    logic [31:0] w;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = fetch_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    d_ready     = ($urandom_range(99) < ready_pct);
    redirect    = redir_once || ($urandom_range(999) < redir_pml);
    tgt         = redir_once ? redir_target : ({$urandom, $urandom} & ~64'h3);
    redirect_pc = tgt;
    redir_once  = 1'b0;
    #1;
    granted_now = 1'b0;
    handoff_now = 1'b0;
    if (imem_req) begin
      check_eq("req_addr", imem_addr, model_pc);
      if (imem_gnt) begin
        p.addr = model_pc;
        p.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        pend_q.push_back(p);
        granted_now  = 1'b1;
        last_gnt_cyc = cyc;
      end
    end
    if (redirect) begin
      check_eq("redir_stall", 64'(f_stall), 64'd0);
      check_eq("redir_pred", f_predPC, tgt);
      check_eq("redir_valid", 64'(f_valid), 64'd0);
      model_pc = tgt;
    end else if (f_valid && d_ready) begin
      w        = fetch_word(model_pc);
      exp_pred = ref_pred(w, model_pc);
      check_eq("ho_pc", f_pc, model_pc);
      check_eq("ho_instr", 64'(f_instr), 64'(w));
      check_eq("ho_stall", 64'(f_stall), 64'd0);
      check_eq("ho_pred", f_predPC, exp_pred);
      last_pred        = f_predPC;
      model_pc         = exp_pred;
      handoffs++;
      handoff_now      = 1'b1;
      last_handoff_cyc = cyc;
    end else begin
      check_eq("stall", 64'(f_stall), 64'd1);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_handoff(input int budget, input string tag);
    int h0;
    int n;
    h0 = handoffs;
    n  = 0;
    while (handoffs == h0 && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_handoff_seen"}, 64'(handoffs != h0), 64'd1);
  endtask

  task automatic wait_grant(input int budget, input string tag);
    int n;
    n = 0;
    granted_now = 1'b0;
    while (!granted_now && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_grant_seen"}, 64'(granted_now), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, 64'(imem_req), 64'd0);
    check_eq({tag, "_addr"}, imem_addr, RESET_PC);
    check_eq({tag, "_valid"}, 64'(f_valid), 64'd0);
    check_eq({tag, "_instr"}, 64'(f_instr), 64'h13);
    check_eq({tag, "_pc"}, f_pc, 64'd0);
    check_eq({tag, "_stall"}, 64'(f_stall), 64'd1);
    check_eq({tag, "_pred"}, f_predPC, RESET_PC);
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [63:0] held_pc;
    logic [63:0] held_addr;
    int          n;
    int          h0;

    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    d_ready     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    imem[64'h0]   = 32'h00000013;
    imem[64'h100] = 32'h0080006F;
    imem[64'h200] = 32'hFE000CE3;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // NOP at 0 with zero-wait memory: grant n, handoff n+2, predicted 4.
    wait_handoff(20, "nop");
    check_eq("nop_pred", last_pred, 64'h4);
    check_eq("nop_latency", 64'(last_handoff_cyc - last_gnt_cyc), 64'd2);
    check_eq("nop_stall_after", 64'(f_stall), 64'd1);

    // JAL +8 at 0x100.
    redir_once = 1'b1; redir_target = 64'h100;
    step();
    wait_handoff(20, "jal");
    check_eq("jal_pred", last_pred, 64'h108);

    // Backward branch taken, then forward branch not taken, at 0x200.
    redir_once = 1'b1; redir_target = 64'h200;
    step();
    wait_handoff(20, "bneg");
    check_eq("bneg_pred", last_pred, 64'h1F8);
    imem[64'h200] = 32'h00000463;
    redir_once = 1'b1; redir_target = 64'h200;
    step();
    wait_handoff(20, "bpos");
    check_eq("bpos_pred", last_pred, 64'h204);

    // Decode stalls three cycles, handoff on the fourth.
    ready_pct = 0;
    n = 0;
    while (!f_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("hold_valid_seen", 64'(f_valid), 64'd1);
    held_instr = f_instr;
    held_pc    = f_pc;
    repeat (3) begin
      step();
      check_eq("hold_valid", 64'(f_valid), 64'd1);
      check_eq("hold_instr", 64'(f_instr), 64'(held_instr));
      check_eq("hold_pc", f_pc, held_pc);
    end
    ready_pct = 100;
    step();
    check_eq("hold_release", 64'(handoff_now), 64'd1);

    // Redirect while waiting: the late response must be dropped.
    lat_min = 2; lat_max = 2;
    wait_grant(20, "kill");
    redir_once = 1'b1; redir_target = 64'h400;
    step();
    check_eq("kill_req", 64'(imem_req), 64'd1);
    check_eq("kill_addr", imem_addr, 64'h400);
    repeat (3) begin
      step();
      check_eq("kill_no_valid", 64'(f_valid), 64'd0);
    end
    wait_handoff(30, "kill");

    // Grant withheld for five cycles: request held stable.
    lat_min = 0; lat_max = 2;
    gnt_pct = 0;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    held_addr = imem_addr;
    repeat (5) begin
      check_eq("nognt_req", 64'(imem_req), 64'd1);
      check_eq("nognt_addr", imem_addr, held_addr);
      step();
    end
    gnt_pct = 100;
    wait_handoff(20, "nognt");

    // Asynchronous reset while a response is outstanding.
    lat_min = 2; lat_max = 2;
    wait_grant(20, "mid");
    imem_rvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    pend_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = RESET_PC;
    @(posedge clk);
    #1;
    wait_handoff(20, "post_rst");

    // Randomized traffic.
    gnt_pct = 70; ready_pct = 60; redir_pml = 30; lat_min = 0; lat_max = 2;
    h0 = handoffs;
    repeat (3000) step();
    check_eq("rand_progress", 64'(handoffs - h0 > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
